// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; the ovf wire exists only with PIPELINED_ADDER_OVF_EN.
interface pipelined_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one SEG-bit carry segment per stage; PIPELINED_ADDER_OVF_EN adds signed overflow.
// Latency STAGES cycles, one beat per cycle.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  // a/bx keep full width so every stage has one shape; bits below the
  // active segment are never read again, s bits above it are not yet valid.
  typedef struct packed {
    logic             v;
    logic             c;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             am;
    logic             bm;
    logic             ov;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t           st [STAGES];
  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cx;

  assign bx = bus.sub ? ~bus.b : bus.b;
  assign cx = bus.cin ^ bus.sub;

  assign adv           = !st[STAGES-1].v || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = st[STAGES-1].v;
  assign bus.sum       = st[STAGES-1].s;
  assign bus.cout      = st[STAGES-1].c;
`ifdef PIPELINED_ADDER_OVF_EN
  assign bus.ovf       = st[STAGES-1].ov;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t       src;
    stage_t       nxt;
    logic [SEG:0] seg_sum;

    if (k == 0) begin : g_src_in
      always_comb begin
        src    = '0;
        src.v  = bus.in_valid;
        src.c  = cx;
        src.a  = bus.a;
        src.bx = bx;
`ifdef PIPELINED_ADDER_OVF_EN
        src.am = bus.a[WIDTH-1];
        src.bm = bx[WIDTH-1];
`endif
      end
    end else begin : g_src_prev
      assign src = st[k-1];
    end

    assign seg_sum = {1'b0, src.a[k*SEG +: SEG]} + {1'b0, src.bx[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, src.c};

    always_comb begin
      nxt                  = src;
      nxt.c                = seg_sum[SEG];
      nxt.s[k*SEG +: SEG]  = seg_sum[SEG-1:0];
`ifdef PIPELINED_ADDER_OVF_EN
      // The sum MSB is only known once the top segment resolves.
      if (k == STAGES - 1) begin
        nxt.ov = (src.am == src.bm) && (seg_sum[SEG-1] != src.am);
      end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st[k] <= '0;
      end else if (adv) begin
        st[k] <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: 8-bit/2-stage directed cases plus 32-bit/4-stage randomized traffic.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8))  bus8 ();
  pipelined_adder_if #(.WIDTH(32)) bus32 ();

  pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  int   checks = 0;
  int   errors = 0;
  int   rx32   = 0;
  bit   done8  = 1'b0;
  bit   done32 = 1'b0;

  // Plain-integer reference: modular result, borrow rule for cout, signed range for ovf.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t   e;
    longint ua, ub, ci, full, half, r, sa, sb, sr;
    ua   = longint'(a);
    ub   = longint'(b);
    ci   = cin ? 64'd1 : 64'd0;
    full = longint'(1) << w;
    half = full / 2;
    r    = sub ? (ua - ub - ci) : (ua + ub + ci);
    e.s  = 32'(r & (full - 1));
    e.c  = sub ? (ua >= ub + ci) : (r >= full);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sr   = sub ? (sa - sb - ci) : (sa + sb + ci);
    e.o  = (sr >= half) || (sr < -half);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_beat8", 32'(bus8.out_valid), 32'd0);
      end else begin
        e = q8.pop_front();
        check("sum8", 32'(bus8.sum), e.s);
        check("cout8", 32'(bus8.cout), 32'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf8", 32'(bus8.ovf), 32'(e.o));
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus32.out_valid && bus32.out_ready) begin
      if (q32.size() == 0) begin
        check("unexpected_beat32", 32'(bus32.out_valid), 32'd0);
      end else begin
        e = q32.pop_front();
        rx32++;
        check("sum32", bus32.sum, e.s);
        check("cout32", 32'(bus32.cout), 32'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
        check("ovf32", 32'(bus32.ovf), 32'(e.o));
`endif
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output int waited);
    logic ok;
    waited = 0;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1;
    do begin
      @(negedge clk); ok = bus8.in_ready;
      @(posedge clk);
      if (!ok) waited++;
    end while (!ok && waited < 1000);
    #1; bus8.in_valid = 1'b0;
    check("accept8", 32'(ok), 32'd1);
    if (ok) q8.push_back(model(8, {24'd0, a}, {24'd0, b}, cin, sub));
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub);
    logic ok;
    int   waited = 0;
    bus32.a = a; bus32.b = b; bus32.cin = cin; bus32.sub = sub; bus32.in_valid = 1'b1;
    do begin
      @(negedge clk); ok = bus32.in_ready;
      @(posedge clk);
      if (!ok) waited++;
    end while (!ok && waited < 1000);
    #1; bus32.in_valid = 1'b0;
    check("accept32", 32'(ok), 32'd1);
    if (ok) q32.push_back(model(32, a, b, cin, sub));
  endtask

  task automatic wait_drain8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain8", 32'(q8.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;  bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b1;

    #2;
    check("reset_out_valid8", 32'(bus8.out_valid), 32'd0);
    check("reset_in_ready8", 32'(bus8.in_ready), 32'd1);
    check("reset_sum8", 32'(bus8.sum), 32'd0);
    check("reset_cout8", 32'(bus8.cout), 32'd0);
    check("reset_out_valid32", 32'(bus32.out_valid), 32'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // Full-width ripple into an empty pipe, with latency observed directly.
    send8(8'hFF, 8'h01, 1'b0, 1'b0, w);
    @(negedge clk); check("latency_early", 32'(bus8.out_valid), 32'd0);
    @(negedge clk); check("latency_on_time", 32'(bus8.out_valid), 32'd1);
    @(posedge clk); #1;

    send8(8'h05, 8'h07, 1'b0, 1'b1, w);
    send8(8'h07, 8'h05, 1'b1, 1'b1, w);
    send8(8'h7F, 8'h01, 1'b0, 1'b0, w);
    send8(8'h80, 8'h01, 1'b0, 1'b1, w);
    send8(8'h10, 8'h20, 1'b0, 1'b0, w);
    wait_drain8();

    // Backpressure: fill, stall for five cycles with a beat waiting, release.
    bus8.out_ready = 1'b0;
    send8(8'h01, 8'h10, 1'b0, 1'b0, w);
    send8(8'h02, 8'h10, 1'b0, 1'b0, w);
    bus8.a = 8'h03; bus8.b = 8'h10; bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus8.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus8.out_valid), 32'd1);
      check("stall_sum", 32'(bus8.sum), 32'h11);
    end
    @(posedge clk); #1;
    bus8.out_ready = 1'b1;
    send8(8'h03, 8'h10, 1'b0, 1'b0, w);
    send8(8'h04, 8'h10, 1'b0, 1'b0, w);
    wait_drain8();

    // Reset with two beats in flight; neither may surface afterwards.
    send8(8'h21, 8'h01, 1'b0, 1'b0, w);
    send8(8'h22, 8'h01, 1'b0, 1'b0, w);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("midrst_sum", 32'(bus8.sum), 32'd0);
    check("midrst_cout", 32'(bus8.cout), 32'd0);
    q8.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    send8(8'h30, 8'h0F, 1'b0, 1'b0, w);
    check("accept_first_edge_after_rst", 32'(w), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    wait_drain8();

    fork
      begin : drv32
        logic [31:0] ra, rb;
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          ra = $urandom;
          case ($urandom_range(7))
            0:       rb = ~ra;
            1:       rb = 32'h1;
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
          endcase
          send32(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        done32 = 1'b1;
      end
      begin : drv8
        int w8;
        for (int i = 0; i < 400; i++) begin
          while ($urandom_range(2) == 0) begin @(posedge clk); #1; end
          send8(8'($urandom), 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), w8);
        end
        done8 = 1'b1;
      end
      begin : rdy
        while (!(done32 && done8)) begin
          @(posedge clk); #1;
          bus32.out_ready = ($urandom_range(3) != 0);
          bus8.out_ready  = 1'($urandom_range(1));
        end
        bus32.out_ready = 1'b1;
        bus8.out_ready  = 1'b1;
      end
    join

    begin
      int n = 0;
      while ((q32.size() != 0 || q8.size() != 0) && n < 2000) begin
        @(posedge clk); n++;
      end
    end
    #1;
    check("drain32", 32'(q32.size()), 32'd0);
    check("drain8_random", 32'(q8.size()), 32'd0);
    check("count32", 32'(rx32), 32'd10000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
